// File: rtl/serial_addsub_if.sv
// Handshake and operand bundle for the bit-serial adder/subtractor.
// The driver uses master; the arithmetic unit uses slave.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, op_a, op_b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder cell reused over WIDTH cycles,
// LSB first, with carry-out and signed overflow.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_addsub_if.slave        bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             sub_q, sub_d;

    logic s_bit;
    logic c_next;
    logic c_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            sub_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sub_q    <= sub_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sub_d    = sub_q;

        s_bit  = sa_q[0] ^ sb_q[0] ^ carry_q;
        c_next = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) |
                 (sb_q[0] & carry_q);
        // carry into the MSB cell, valid while cnt_q == LAST
        c_msb  = carry_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    sa_d    = bus.op_a;
                    sb_d    = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_d = bus.sub;
                    acc_d   = '0;
                    cnt_d   = '0;
                    opa_d   = bus.op_a;
                    opb_d   = bus.op_b;
                    sub_d   = bus.sub;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = c_next;
                acc_d   = {s_bit, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = {s_bit, acc_q[WIDTH-1:1]};
                    cout_d   = c_next;
                    ovf_d    = c_msb ^ c_next;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

    logic [WIDTH:0] ref_sum;

    assign ref_sum = {1'b0, opa_q} +
                     (sub_q ? ({1'b0, ~opb_q} + (WIDTH+1)'(1))
                            : {1'b0, opb_q});

    always_comb begin
        assert #0 (!(bus.busy && bus.done))
            else $error("busy and done both high");
        if (bus.done) begin
            assert #0 ({bus.cout, bus.result} == ref_sum)
                else $error("serial result disagrees with parallel sum");
        end
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial, sequential counterpart of the combinational full-adder datapath: one full-adder cell is reused over WIDTH clock cycles, LSB first.
- Adds or subtracts two WIDTH-bit operands under a start/busy/done handshake.
- Result is reported with carry-out and signed overflow.
- Sits behind a control FSM or bench driver where area matters more than latency; full-adder equations and assertion-checked behaviour match the existing parallel adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE state
sub  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with start
op_a  input  WIDTH  operand A; sampled with start
op_b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  single-cycle pulse: result/cout/ovf valid
result  output  WIDTH  sum/difference, modulo 2^WIDTH
cout  output  1  carry-out of MSB; for subtract, 1 = no borrow
ovf  output  1  signed (two's complement) overflow

Behaviour:
- Reset (async assert, sync-safe release):
  - State = IDLE.
  - busy = 0, done = 0, result = 0, cout = 0, ovf = 0.
  - Internal shift registers, carry and counter = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start = 1.
  - RUN -> DONE after WIDTH RUN cycles.
  - DONE -> RUN if start = 1, otherwise DONE -> IDLE.
- On an accepted start edge:
  - sa <= op_a.
  - sb <= sub ? ~op_b : op_b.
  - carry <= sub.
  - bit count <= 0.
  - busy goes high the next cycle.
- Each RUN edge, one bit is processed:
  - s = sa[0]^sb[0]^carry.
  - carry <= (sa[0]&sb[0]) | (sa[0]&carry) | (sb[0]&carry).
  - sa and sb shift right by 1.
  - s shifts into the MSB of the internal accumulator (right shift).
  - count increments.
- On bit WIDTH-1, the carry-in to that bit (before update) is captured as c_msb.
- Completion (WIDTH-th RUN edge):
  - result <= accumulator including the final bit.
  - cout <= final carry.
  - ovf <= c_msb ^ final carry.
  - State -> DONE.
- done = 1 only in DONE state, exactly one cycle.
- result, cout and ovf:
  - change only at the completion edge;
  - hold stable through DONE, IDLE and the next RUN until that operation completes;
  - are never partially updated.
- Latency: start sampled at edge N -> done high in the cycle following edge N+WIDTH (WIDTH+1 cycles from start to done). Throughput: one operation per WIDTH+1 cycles.
- start while busy = 1: ignored; operands are not resampled and the in-flight operation is unaffected.
- start during DONE (back-to-back):
  - The done pulse still occurs.
  - The new operation is accepted at that edge.
  - busy is high the next cycle.
- sub, op_a and op_b may change freely after the start edge; only sampled values are used.
- Reset asserted mid-RUN: immediate abort to IDLE with all outputs at reset values; no done pulse.
- Counter width is $clog2(WIDTH+1); no wrap-around inside RUN.
- Embedded checks:
  - deferred immediate assertion (assert #0) that busy and done are never both 1;
  - on done, assertion that {cout,result} equals op_a_sampled + (sub ? ~op_b_sampled + 1 : op_b_sampled) truncated to WIDTH+1 bits.

Test Plan:
- WIDTH=8, add 100+27, start at edge 0:
  - busy = 1 for 8 cycles, done at cycle 9;
  - result = 127, cout = 0, ovf = 0.
- Add 127+1 -> result = 128 (0x80), cout = 0, ovf = 1. Add 200+100 -> result = 44, cout = 1, ovf = 0.
- Sub 5-7 -> result = 254 (0xFE), cout = 0 (borrow), ovf = 0. Sub 0x80-1 -> result = 0x7F, cout = 1, ovf = 1.
- Start pulsed with new operands at cycle 3 of a run:
  - ignored;
  - original result delivered at cycle 9;
  - exactly one done pulse.
- Back-to-back:
  - start held high in the DONE cycle with 10+20;
  - first done seen, busy = 1 the next cycle;
  - second done 9 cycles later with result = 30.
- rst_n low for 1 cycle mid-RUN (cycle 4):
  - busy = 0 immediately;
  - result/cout/ovf = 0;
  - no done pulse;
  - a fresh start afterwards completes normally.
